// File: rtl/rom_image_loader_pkg.sv
// Shared types and constants for the ROM image loader: FSM encoding, error codes, default pad byte.
package rom_image_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StData,
    StCsum,
    StFill,
    StDone,
    StError
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;

  localparam logic [7:0] DEFAULT_FILL_BYTE = 8'hFF;

endpackage

// File: rtl/rom_image_loader.sv
// Writer side of the ROM image store: parses a LEN_LO/LEN_HI/data/CSUM byte frame, writes it from
// address 0, verifies the checksum, pads the tail and releases the CPU hold once the image is good.
module rom_image_loader
  import rom_image_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 15,
  parameter logic [7:0]  FILL_BYTE   = DEFAULT_FILL_BYTE,
  parameter bit          FILL_ENABLE = 1'b1
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [7:0]            i_in_data,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  output logic [ADDR_WIDTH-1:0] o_wr_address,
  output logic [7:0]            o_wr_data,
  output logic                  o_wr_en,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [1:0]            o_error,
  output logic                  o_cpu_hold
);

  // One extra counter bit so a full-depth image ends at D without wrapping to 0.
  localparam int unsigned       CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]     DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_e                r_state, w_state_next;
  logic [7:0]            r_len_lo, w_len_lo_next;
  logic [CW-1:0]         r_len, w_len_next;
  logic [CW-1:0]         r_cnt, w_cnt_next;
  logic [7:0]            r_sum, w_sum_next;
  logic                  r_wr_en, w_wr_en_next;
  logic [ADDR_WIDTH-1:0] r_wr_addr, w_wr_addr_next;
  logic [7:0]            r_wr_data, w_wr_data_next;
  logic [1:0]            r_error, w_error_next;

  logic                  w_in_ready;
  logic                  w_xfer;
  logic [15:0]           w_len;
  logic                  w_len_bad;
  logic [CW-1:0]         w_cnt_inc;

  assign w_in_ready = (r_state == StLenLo) || (r_state == StLenHi) ||
                      (r_state == StData)  || (r_state == StCsum);
  assign w_xfer     = i_in_valid && w_in_ready;
  assign w_len      = {i_in_data, r_len_lo};
  assign w_len_bad  = (w_len == 16'd0) || (32'(w_len) > 32'(DEPTH));
  assign w_cnt_inc  = r_cnt + CW'(1);

  always_comb begin
    w_state_next   = r_state;
    w_len_lo_next  = r_len_lo;
    w_len_next     = r_len;
    w_cnt_next     = r_cnt;
    w_sum_next     = r_sum;
    w_wr_en_next   = 1'b0;
    w_wr_addr_next = r_wr_addr;
    w_wr_data_next = r_wr_data;
    w_error_next   = r_error;

    if (i_abort) begin
      // Abort beats start and any same-cycle byte; nothing is written.
      w_state_next = StIdle;
      w_error_next = ERR_NONE;
    end else begin
      case (r_state)
        StIdle, StDone, StError: begin
          if (i_start) begin
            w_state_next = StLenLo;
            w_cnt_next   = '0;
            w_sum_next   = '0;
            w_error_next = ERR_NONE;
          end
        end
        StLenLo: begin
          if (w_xfer) begin
            w_len_lo_next = i_in_data;
            w_state_next  = StLenHi;
          end
        end
        StLenHi: begin
          if (w_xfer) begin
            if (w_len_bad) begin
              w_state_next = StError;
              w_error_next = ERR_LEN;
            end else begin
              w_len_next   = CW'(w_len);
              w_state_next = StData;
            end
          end
        end
        StData: begin
          if (w_xfer) begin
            w_wr_en_next   = 1'b1;
            w_wr_addr_next = r_cnt[ADDR_WIDTH-1:0];
            w_wr_data_next = i_in_data;
            w_sum_next     = r_sum + i_in_data;
            w_cnt_next     = w_cnt_inc;
            if (w_cnt_inc == r_len) begin
              w_state_next = StCsum;
            end
          end
        end
        StCsum: begin
          if (w_xfer) begin
            if (i_in_data != r_sum) begin
              w_state_next = StError;
              w_error_next = ERR_CSUM;
            end else if (FILL_ENABLE && (r_len != DEPTH)) begin
              w_state_next = StFill;
            end else begin
              w_state_next = StDone;
            end
          end
        end
        StFill: begin
          w_wr_en_next   = 1'b1;
          w_wr_addr_next = r_cnt[ADDR_WIDTH-1:0];
          w_wr_data_next = FILL_BYTE;
          w_cnt_next     = w_cnt_inc;
          if (w_cnt_inc == DEPTH) begin
            w_state_next = StDone;
          end
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= StIdle;
      r_len_lo  <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_sum     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_error   <= ERR_NONE;
    end else begin
      r_state   <= w_state_next;
      r_len_lo  <= w_len_lo_next;
      r_len     <= w_len_next;
      r_cnt     <= w_cnt_next;
      r_sum     <= w_sum_next;
      r_wr_en   <= w_wr_en_next;
      r_wr_addr <= w_wr_addr_next;
      r_wr_data <= w_wr_data_next;
      r_error   <= w_error_next;
    end
  end

  assign o_in_ready   = w_in_ready;
  assign o_wr_address = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_wr_en      = r_wr_en;
  assign o_busy       = (r_state != StIdle) && (r_state != StDone) && (r_state != StError);
  assign o_done       = (r_state == StDone);
  assign o_error      = r_error;
  assign o_cpu_hold   = (r_state != StDone);

endmodule
